// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Purpose  : Shared definitions for the programmable sequence detector:
//            length-field width helper, detector state encoding and the
//            legacy "0110" reset pattern/length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  // Width of a field able to hold 0..pat_w inclusive.
  function automatic int LEN_W(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Detector state; held implicitly in the fill counter.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } det_state_e;

  // Legacy overlapping "0110" detector defaults (right-aligned).
  localparam logic [31:0] c_DEF_PAT = 32'h0000_0006;
  localparam int          c_DEF_LEN = 4;

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/seq_match_cmp.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_cmp
// Purpose  : Combinational compare of the bit history against the pattern,
//            limited to the low i_len bits and qualified by a care mask
//            (mask bit 0 = don't care).
// Ports    : i_hist  - shifted history, newest bit at index 0
//            i_pat   - right-aligned pattern
//            i_mask  - per-bit care mask
//            i_len   - active pattern length
//            o_eq    - 1 when every cared-for bit below i_len matches
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  localparam int LW   = LEN_W(PAT_W)
) (
  input  logic [PAT_W-1:0] i_hist,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [PAT_W-1:0] i_mask,
  input  logic [LW-1:0]    i_len,
  output logic             o_eq
);

  logic [PAT_W-1:0] w_len_mask;

  // Thermometer mask selecting bits [i_len-1:0].
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_len_mask
      assign w_len_mask[gi] = (LW'(gi) < i_len);
    end
  endgenerate

  assign o_eq = ~|((i_hist ^ i_pat) & i_mask & w_len_mask);

endmodule : seq_match_cmp
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Programmable serial sequence detector. Pattern (1..PAT_W bits)
//            and length load at run time; overlapping or non-overlapping
//            matching; registered one-cycle match pulse and a saturating
//            match counter. Reset defaults reproduce the "0110" detector.
// Options  : `define SEQ_DETECT_PROG_MASK_EN adds pat_mask_value, a per-bit
//            care mask loaded with the pattern (0 = don't care).
// Ports    : clk            - rising-edge clock
//            reset          - asynchronous active-low reset
//            in_valid       - qualifies in_bit
//            in_bit         - serial data bit
//            overlap_en     - 1 = overlapping, 0 = non-overlapping matches
//            pat_load       - load pat_value/pat_len (and mask) this cycle
//            pat_value      - new pattern, bit [pat_len-1] received first
//            pat_len        - new pattern length (valid 1..PAT_W)
//            pat_mask_value - new care mask (mask build only)
//            cnt_clr        - synchronous clear of match_count
//            match          - registered one-cycle match pulse
//            match_count    - saturating match count
//            load_err       - one-cycle pulse on a rejected load
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(c_DEF_PAT),
  parameter int               DEF_LEN = c_DEF_LEN,
  localparam int              LW      = LEN_W(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic [LW-1:0]    pat_len,
`ifdef SEQ_DETECT_PROG_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_value,
`endif
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             load_err
);

  localparam logic [LW-1:0] c_pat_w   = LW'(PAT_W);
  localparam logic [LW-1:0] c_def_len = LW'(DEF_LEN);

  // Registers
  logic [PAT_W-1:0] r_hist;
  logic [LW-1:0]    r_fill;
  logic [PAT_W-1:0] r_pat;
  logic [LW-1:0]    r_len;
  logic             r_match;
  logic [CNT_W-1:0] r_count;
  logic             r_load_err;

  // Combinational
  logic [PAT_W-1:0] w_hist_sh;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [LW-1:0]    w_fill_inc;
  logic [LW-1:0]    w_fill_nxt;
  logic [PAT_W-1:0] w_mask;
  logic             w_acc;
  logic             w_eq;
  logic             w_hit;
  logic             w_len_ok;
  logic [CNT_W-1:0] w_count_nxt;
  det_state_e       w_state_acc;

`ifdef SEQ_DETECT_PROG_MASK_EN
  logic [PAT_W-1:0] r_mask;
  assign w_mask = r_mask;
`else
  assign w_mask = '1;
`endif

  // A load takes the cycle; any bit offered alongside it is dropped.
  assign w_acc      = in_valid & ~pat_load;
  assign w_hist_sh  = {r_hist[PAT_W-2:0], in_bit};
  assign w_fill_inc = (r_fill == c_pat_w) ? r_fill : r_fill + LW'(1);
  assign w_len_ok   = (pat_len != '0) && (pat_len <= c_pat_w);

  // Compare runs on the post-shift history so the hit lines up with the
  // bit that completes the pattern.
  seq_match_cmp #(
    .PAT_W (PAT_W)
  ) u_cmp (
    .i_hist (w_hist_sh),
    .i_pat  (r_pat),
    .i_mask (w_mask),
    .i_len  (r_len),
    .o_eq   (w_eq)
  );

  // ---------------- state (hist/fill) register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  // State after an accepted bit: ARMED once the fill reaches the length.
  assign w_state_acc = (w_fill_inc >= r_len) ? ARMED : FILLING;

  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (pat_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (in_valid) begin
      w_hist_nxt = w_hist_sh;
      // Non-overlap: restart the fill; stale history is masked by fill.
      if (w_hit && !overlap_en) begin
        w_fill_nxt = '0;
      end else begin
        w_fill_nxt = w_fill_inc;
      end
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    w_hit       = w_acc && (w_state_acc == ARMED) && w_eq;
    w_count_nxt = r_count;
    if (cnt_clr) begin
      w_count_nxt = '0;
    end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat      <= DEF_PAT;
      r_len      <= c_def_len;
      r_match    <= 1'b0;
      r_count    <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_match    <= w_hit;
      r_count    <= w_count_nxt;
      r_load_err <= pat_load & ~w_len_ok;
      if (pat_load && w_len_ok) begin
        r_pat <= pat_value;
        r_len <= pat_len;
      end
    end
  end

`ifdef SEQ_DETECT_PROG_MASK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '1;
    end else if (pat_load && w_len_ok) begin
      r_mask <= pat_mask_value;
    end
  end
`endif

  assign match       = r_match;
  assign match_count = r_count;
  assign load_err    = r_load_err;

endmodule : seq_detect_prog
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Purpose  : Self-checking bench for seq_detect_prog: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

  localparam int PAT_W    = 8;
  localparam int CNT_W    = 2;
  localparam int LEN_W    = $clog2(PAT_W + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef SEQ_DETECT_PROG_MASK_EN
  localparam bit c_mask_on = 1'b1;
`else
  localparam bit c_mask_on = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             overlap_en = 1'b1;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_value = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             load_err;
`ifdef SEQ_DETECT_PROG_MASK_EN
  logic [PAT_W-1:0] pat_mask_value = '1;
`endif

  seq_detect_prog #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .overlap_en     (overlap_en),
    .pat_load       (pat_load),
    .pat_value      (pat_value),
    .pat_len        (pat_len),
`ifdef SEQ_DETECT_PROG_MASK_EN
    .pat_mask_value (pat_mask_value),
`endif
    .cnt_clr        (cnt_clr),
    .match          (match),
    .match_count    (match_count),
    .load_err       (load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bits accepted since the last clear, oldest first.
  bit               q[$];
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_mask;
  int               m_len;
  int               m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat  = PAT_W'(8'b0000_0110);
    m_mask = '1;
    m_len  = 4;
    m_cnt  = 0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check outputs.
  task automatic drive(input logic v, input logic b, input logic ov, input logic ld,
                       input logic [PAT_W-1:0] pv, input logic [LEN_W-1:0] pl,
                       input logic clr, input logic [PAT_W-1:0] pm);
    bit hit;
    bit exp_err;
    int n;
    in_valid   = v;
    in_bit     = b;
    overlap_en = ov;
    pat_load   = ld;
    pat_value  = pv;
    pat_len    = pl;
    cnt_clr    = clr;
`ifdef SEQ_DETECT_PROG_MASK_EN
    pat_mask_value = pm;
`endif
    @(posedge clk);
    hit     = 1'b0;
    exp_err = 1'b0;
    if (ld) begin
      if (int'(pl) >= 1 && int'(pl) <= PAT_W) begin
        m_pat  = pv;
        m_len  = int'(pl);
        m_mask = c_mask_on ? pm : '1;
      end else begin
        exp_err = 1'b1;
      end
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > PAT_W) void'(q.pop_front());
      n = q.size();
      if (n >= m_len) begin
        hit = 1'b1;
        // k-th most recent bit must equal pattern bit k where cared for.
        for (int k = 0; k < m_len; k++) begin
          if (m_mask[k] && (q[n-1-k] != m_pat[k])) hit = 1'b0;
        end
      end
      if (hit && !ov) q.delete();
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    #1;
    chk("match", 32'(match), 32'(hit));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("load_err", 32'(load_err), 32'(exp_err));
  endtask

  task automatic bit_in(input logic b, input logic ov);
    drive(1'b1, b, ov, 1'b0, '0, '0, 1'b0, '1);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    reset    = 1'b0;
    #2;
    model_reset();
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [6:0] s7;
    logic [15:0] s16;
    bit cur_ov;
    int r;
    logic [LEN_W-1:0] ln;

    model_reset();
    @(posedge clk);
    #1;
    chk("por_match", 32'(match), 32'd0);
    chk("por_count", 32'(match_count), 32'd0);
    reset = 1'b1;

    // Default "0110", overlapping: hits after bits 4 and 7.
    s7 = 7'b0110110;
    for (int i = 6; i >= 0; i--) bit_in(s7[i], 1'b1);
    chk("t1_count", 32'(match_count), 32'd2);

    // Same stream, non-overlapping: single hit.
    do_reset();
    for (int i = 6; i >= 0; i--) bit_in(s7[i], 1'b0);
    chk("t2_count", 32'(match_count), 32'd1);

    // Pattern 101 with gaps between bits.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, PAT_W'(3'b101), LEN_W'(3), 1'b0, '1);
    bit_in(1'b1, 1'b1); gap();
    bit_in(1'b0, 1'b1); gap();
    bit_in(1'b1, 1'b1); gap();
    bit_in(1'b0, 1'b1); gap();
    bit_in(1'b1, 1'b1); gap();
    chk("t3_count", 32'(match_count), 32'd2);

    // Rejected loads keep the default pattern.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, LEN_W'(0), 1'b0, '1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, LEN_W'(PAT_W + 1), 1'b0, '1);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    chk("t4_count", 32'(match_count), 32'd1);

    // Saturation with CNT_W=2, then clear coincident with the 6th hit.
    do_reset();
    s16 = 16'b0110110110110110;
    for (int i = 15; i >= 0; i--) bit_in(s16[i], 1'b1);
    chk("t5_sat", 32'(match_count), 32'd3);
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, '1);
    chk("t5_clr_count", 32'(match_count), 32'd0);
    chk("t5_clr_match", 32'(match), 32'd1);

    // Reset mid-stream drops the partial pattern; a pending pulse is killed.
    do_reset();
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    do_reset();
    bit_in(1'b0, 1'b1);
    chk("t6_count", 32'(match_count), 32'd0);
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    do_reset();

`ifdef SEQ_DETECT_PROG_MASK_EN
    // Mask 1001 on "0110": middle bits are don't-care.
    drive(1'b0, 1'b0, 1'b1, 1'b1, PAT_W'(4'b0110), LEN_W'(4), 1'b0, PAT_W'(4'b1001));
    for (int i = 0; i < 4; i++) bit_in(1'b0, 1'b1);
    chk("t7_mask_count", 32'(match_count), 32'd1);
    do_reset();
`endif

    // Randomized traffic against the model.
    cur_ov = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      if ($urandom_range(0, 19) == 0) cur_ov = ~cur_ov;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        ln = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 10))
                                         : LEN_W'($urandom_range(1, 3));
        drive($urandom_range(0, 1) == 1, 1'b1, cur_ov, 1'b1, PAT_W'($urandom),
              ln, $urandom_range(0, 9) == 0,
              ($urandom_range(0, 1) == 1) ? '1 : PAT_W'($urandom));
      end else begin
        drive(r < 70, $urandom_range(0, 1) == 1, cur_ov, 1'b0, PAT_W'($urandom),
              '0, $urandom_range(0, 49) == 0, '1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_detect_prog
`default_nettype wire
